// File: rtl/nave_controle.sv
// Ship controller: ticked 4-way movement clamped to the playfield, plus the serve/launch FSM.
// Optional feature: define NAVE_ACCEL_EN for a per-axis speed ramp 1..STEP.
module nave_controle #(
  parameter int COORD_W  = 10,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int START_X  = 350,
  parameter int START_Y  = 240,
  parameter int STEP     = 2,
  parameter int TICK_DIV = 250000
) (
  input  logic               CLOCK_50,
  input  logic               reset_n,
  input  logic [3:0]         keysout,
  input  logic               lancar,
  input  logic               pausa,
  input  logic               reiniciarJogo,
  input  logic               bateu,
  input  logic [COORD_W-1:0] largura_nave,
  input  logic [COORD_W-1:0] altura_nave,
  output logic [COORD_W-1:0] x_nave,
  output logic [COORD_W-1:0] y_nave,
  output logic               iniciarBola,
  output logic               movendo,
  output logic               estado_dbg_o
);

  // Working width: one extra bit for the sum plus a sign bit for moves past zero.
  localparam int AW    = COORD_W + 2;
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [AW-1:0]      TELA_W  = AW'(SCREEN_W);
  localparam logic [AW-1:0]      TELA_H  = AW'(SCREEN_H);
  localparam logic [AW-1:0]      PASSO   = AW'(STEP);
  localparam logic [COORD_W-1:0] X0      = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] Y0      = COORD_W'(START_Y);

  typedef enum logic {ESPERA = 1'b0, VOO = 1'b1} estado_t;

  typedef struct packed {
    logic [COORD_W-1:0] pos;
    logic               clamp;
  } eixo_t;

  // One axis: step toward the single pressed key, then saturate to [0, tela-tam].
  // A size at or beyond the screen pins the axis to 0.
  function automatic eixo_t mover(
    input logic [COORD_W-1:0] pos,
    input logic               k_mais,
    input logic               k_menos,
    input logic [COORD_W-1:0] tam,
    input logic [AW-1:0]      tela,
    input logic [AW-1:0]      passo
  );
    logic signed [AW-1:0] lim;
    logic signed [AW-1:0] alvo;
    eixo_t                r;
    lim = $signed(tela) - $signed(AW'(tam));
    if (lim[AW-1]) lim = '0;
    alvo = $signed(AW'(pos));
    if (k_mais && !k_menos)      alvo = alvo + $signed(passo);
    else if (k_menos && !k_mais) alvo = alvo - $signed(passo);
    r.clamp = 1'b0;
    if (alvo[AW-1]) begin
      alvo    = '0;
      r.clamp = 1'b1;
    end else if (alvo > lim) begin
      alvo    = lim;
      r.clamp = 1'b1;
    end
    r.pos = alvo[COORD_W-1:0];
    return r;
  endfunction

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               mov_q, mov_d;
  logic               lancar_q;
  logic               lancar_sobe;
  logic               tick;
  estado_t            estado_q, estado_d;
  logic [AW-1:0]      vel_x, vel_y;
  eixo_t              nx, ny;

  assign lancar_sobe = lancar && !lancar_q;

  assign nx = mover(x_q, keysout[0], keysout[1], largura_nave, TELA_W, vel_x);
  assign ny = mover(y_q, keysout[3], keysout[2], altura_nave,  TELA_H, vel_y);

  // Tick divider and position update; everything holds while paused.
  always_comb begin
    cnt_d = cnt_q;
    x_d   = x_q;
    y_d   = y_q;
    mov_d = 1'b0;
    tick  = 1'b0;
    if (!pausa) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (tick) begin
      x_d   = nx.pos;
      y_d   = ny.pos;
      mov_d = (nx.pos != x_q) || (ny.pos != y_q);
    end
  end

`ifdef NAVE_ACCEL_EN
  logic [AW-1:0] vel_x_q, vel_x_d, vel_y_q, vel_y_d;

  // Speed grows by one per held tick up to STEP; release or a clamp restarts at 1.
  function automatic logic [AW-1:0] rampa(
    input logic [AW-1:0] v,
    input logic          ativo,
    input logic          clamp
  );
    if (!ativo || clamp) return AW'(1);
    if (v >= PASSO) return PASSO;
    return v + 1'b1;
  endfunction

  assign vel_x = vel_x_q;
  assign vel_y = vel_y_q;

  always_comb begin
    vel_x_d = vel_x_q;
    vel_y_d = vel_y_q;
    if (tick) begin
      vel_x_d = rampa(vel_x_q, keysout[0] ^ keysout[1], nx.clamp);
      vel_y_d = rampa(vel_y_q, keysout[2] ^ keysout[3], ny.clamp);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n || reiniciarJogo) begin
      vel_x_q <= AW'(1);
      vel_y_q <= AW'(1);
    end else begin
      vel_x_q <= vel_x_d;
      vel_y_q <= vel_y_d;
    end
  end
`else
  assign vel_x = PASSO;
  assign vel_y = PASSO;
`endif

  // Serve FSM: a launch only counts in ESPERA, a hit only counts in VOO.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      ESPERA:  if (!pausa && lancar_sobe) estado_d = VOO;
      VOO:     if (!pausa && bateu)       estado_d = ESPERA;
      default: estado_d = ESPERA;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n || reiniciarJogo) begin
      cnt_q    <= '0;
      x_q      <= X0;
      y_q      <= Y0;
      mov_q    <= 1'b0;
      lancar_q <= 1'b0;
      estado_q <= ESPERA;
    end else begin
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      mov_q    <= mov_d;
      lancar_q <= lancar;
      estado_q <= estado_d;
    end
  end

  assign x_nave       = x_q;
  assign y_nave       = y_q;
  assign movendo      = mov_q;
  assign iniciarBola  = (estado_q == VOO);
  assign estado_dbg_o = estado_q;

endmodule

// File: tb/tb_nave_controle.sv
// Self-checking bench for nave_controle: per-cycle scoreboard of {x, y, iniciarBola, movendo}.
module tb_nave_controle;

  localparam int COORD_W  = 10;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int START_X  = 350;
  localparam int START_Y  = 240;
  localparam int TICK_DIV = 4;
`ifdef NAVE_ACCEL_EN
  localparam int STEP_P = 3;
  localparam int V0     = 1;
`else
  localparam int STEP_P = 2;
  localparam int V0     = STEP_P;
`endif
  localparam int W = 2 * COORD_W + 2;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [3:0]         keysout = '0;
  logic               lancar = 1'b0;
  logic               pausa = 1'b0;
  logic               reiniciarJogo = 1'b0;
  logic               bateu = 1'b0;
  logic [COORD_W-1:0] largura_nave = 10'd40;
  logic [COORD_W-1:0] altura_nave = 10'd20;
  logic [COORD_W-1:0] x_nave, y_nave;
  logic               iniciarBola, movendo, estado_dbg;

  nave_controle #(
    .COORD_W (COORD_W),
    .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H),
    .START_X (START_X),
    .START_Y (START_Y),
    .STEP    (STEP_P),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .CLOCK_50     (clk),
    .reset_n      (reset_n),
    .keysout      (keysout),
    .lancar       (lancar),
    .pausa        (pausa),
    .reiniciarJogo(reiniciarJogo),
    .bateu        (bateu),
    .largura_nave (largura_nave),
    .altura_nave  (altura_nave),
    .x_nave       (x_nave),
    .y_nave       (y_nave),
    .iniciarBola  (iniciarBola),
    .movendo      (movendo),
    .estado_dbg_o (estado_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  string tag      = "reset";

  // Reference model state
  int   mx = START_X, my = START_Y, vx = V0, vy = V0, fase = 0;
  logic e_ib = 1'b0, e_mov = 1'b0, lan_ant = 1'b0;

  task automatic check_eq(input string t, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s t=%0t got x=%0d y=%0d ib=%0b mov=%0b want x=%0d y=%0d ib=%0b mov=%0b",
               t, $time, obs[W-1 -: COORD_W], obs[COORD_W+1 +: COORD_W], obs[1], obs[0],
               expv[W-1 -: COORD_W], expv[COORD_W+1 +: COORD_W], expv[1], expv[0]);
    end
  endtask

  task automatic mover(input int pos, input int v, input logic kp, input logic km,
                       input int tam, input int tela, output int npos, output int nv);
    int lim, raw;
    logic cl;
    lim = tela - tam;
    if (lim < 0) lim = 0;
    raw = pos;
    if (kp && !km) raw = pos + v;
    else if (km && !kp) raw = pos - v;
    cl = 1'b0;
    if (raw < 0) begin raw = 0; cl = 1'b1; end
    else if (raw > lim) begin raw = lim; cl = 1'b1; end
    npos = raw;
`ifdef NAVE_ACCEL_EN
    nv = (!(kp ^ km) || cl) ? 1 : ((v >= STEP_P) ? STEP_P : v + 1);
`else
    nv = STEP_P;
`endif
  endtask

  // Driver: one clock with the current inputs; the model predicts, pushes, then the DUT is compared.
  task automatic ciclo();
    logic p, rst, rj, lan, bat, rise;
    logic [3:0] k;
    int lw, lh, nx, ny, nvx, nvy;
    p = pausa; rst = reset_n; rj = reiniciarJogo; lan = lancar; bat = bateu; k = keysout;
    lw = int'(largura_nave); lh = int'(altura_nave);
    @(posedge clk);
    if (!rst || rj) begin
      mx = START_X; my = START_Y; vx = V0; vy = V0; fase = 0;
      e_ib = 1'b0; e_mov = 1'b0; lan_ant = 1'b0;
    end else begin
      e_mov = 1'b0;
      if (!p) begin
        rise = lan && !lan_ant;
        if (!e_ib && rise) e_ib = 1'b1;
        else if (e_ib && bat) e_ib = 1'b0;
        if (fase == TICK_DIV - 1) begin
          fase = 0;
          mover(mx, vx, k[0], k[1], lw, SCREEN_W, nx, nvx);
          mover(my, vy, k[3], k[2], lh, SCREEN_H, ny, nvy);
          e_mov = (nx != mx) || (ny != my);
          mx = nx; my = ny; vx = nvx; vy = nvy;
        end else begin
          fase++;
        end
      end
      lan_ant = lan;
    end
    exp_q.push_back({COORD_W'(mx), COORD_W'(my), e_ib, e_mov});
    #1;
    check_eq(tag, {x_nave, y_nave, iniciarBola, movendo}, exp_q.pop_front());
  endtask

  task automatic ciclos(input int n);
    for (int i = 0; i < n; i++) ciclo();
  endtask

  initial begin
    tag = "reset";
    ciclos(2);
    reset_n = 1'b1;

    tag = "direita";
    keysout = 4'b0001;
    ciclos(TICK_DIV * 130);

    tag = "tam_impar";
    largura_nave = 10'd41;
    ciclos(TICK_DIV * 2);

    tag = "esq_dir";
    keysout = 4'b0011;
    ciclos(TICK_DIV * 10);

    tag = "esquerda";
    keysout = 4'b0010;
    ciclos(TICK_DIV * 305);

    tag = "diag_desce";
    keysout = 4'b1001;
    ciclos(TICK_DIV * 10);
    tag = "diag_sobe";
    keysout = 4'b0110;
    ciclos(TICK_DIV * 10);

    tag = "altura_grande";
    keysout = 4'b0000;
    altura_nave = 10'd500;
    ciclos(TICK_DIV * 2);
    altura_nave = 10'd20;

    tag = "lancar";
    lancar = 1'b1; ciclos(2);
    lancar = 1'b0; ciclo();
    tag = "lancar_em_voo";
    lancar = 1'b1; ciclos(2);
    lancar = 1'b0; ciclo();
    tag = "bateu";
    bateu = 1'b1; ciclo();
    bateu = 1'b0; ciclos(2);

    tag = "lancar_e_bateu";
    lancar = 1'b1; bateu = 1'b1; ciclo();
    lancar = 1'b0; bateu = 1'b0; ciclo();
    bateu = 1'b1; ciclo();
    bateu = 1'b0; ciclo();

    tag = "pausa";
    keysout = 4'b0001;
    pausa = 1'b1; ciclos(3);
    lancar = 1'b1; ciclos(5);
    tag = "pos_pausa";
    pausa = 1'b0; ciclos(TICK_DIV * 2);
    lancar = 1'b0; ciclo();
    tag = "novo_lancar";
    lancar = 1'b1; ciclo();
    lancar = 1'b0;
    ciclos(TICK_DIV * 30);

    tag = "reinicio";
    reiniciarJogo = 1'b1; ciclo();
    reiniciarJogo = 1'b0;
    keysout = 4'b0000;
    ciclos(TICK_DIV);

    tag = "rampa";
    keysout = 4'b0001;
    ciclos(TICK_DIV * 4);
    keysout = 4'b0000;
    ciclos(TICK_DIV);
    keysout = 4'b1000;
    ciclos(TICK_DIV * 3);

    tag = "aleatorio";
    for (int i = 0; i < 600; i++) begin
      keysout = 4'($urandom_range(0, 15));
      lancar  = ($urandom_range(0, 3) == 0);
      bateu   = ($urandom_range(0, 9) == 0);
      pausa   = ($urandom_range(0, 7) == 0);
      reiniciarJogo = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) largura_nave = 10'($urandom_range(20, 700));
      if ($urandom_range(0, 49) == 0) altura_nave  = 10'($urandom_range(10, 520));
      ciclo();
    end

    tag = "reset_final";
    reset_n = 1'b0; ciclo();
    reset_n = 1'b1; ciclo();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
